// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front of a 64-bit SRAM.
// Miss/write FSM, selectable write-hit policy, one-cycle flush and saturating hit/miss counters.
module set_assoc_cache_ctrl #(
  parameter int SET_BITS     = 6,
  parameter int TAG_BITS     = 9,
  parameter int WRITE_UPDATE = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  input  logic             flush,
  output logic [31:0]      rdata,
  output logic             freeze,
  output logic [31:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  output logic             sram_r_en,
  output logic             sram_w_en,
  input  logic             sram_ready,
  input  logic [63:0]      sram_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [1:0]       state_dbg
);
  localparam int NUM_SETS = 2**SET_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2} state_t;
  state_t state, state_nxt;

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                word_sel;
  logic                unused_addr_bits;
  assign idx      = addr[SET_BITS+2:3];
  assign tag      = addr[TAG_BITS+SET_BITS+2:SET_BITS+3];
  assign word_sel = addr[2];
  assign unused_addr_bits = ^{addr[1:0], addr[31:TAG_BITS+SET_BITS+3]};

  logic [NUM_SETS-1:0] valid0, valid1, lru;
  logic [TAG_BITS-1:0] tag0  [NUM_SETS];
  logic [TAG_BITS-1:0] tag1  [NUM_SETS];
  logic [63:0]         data0 [NUM_SETS];
  logic [63:0]         data1 [NUM_SETS];

  logic        hit0, hit1, hit;
  logic [63:0] hit_line;
  logic [31:0] hit_word, fill_word;
  assign hit0      = valid0[idx] && (tag0[idx] == tag);
  assign hit1      = valid1[idx] && (tag1[idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_line  = hit0 ? data0[idx] : data1[idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

  // Handshake: the pipeline holds addr/enables stable while freeze=1; sram_ready
  // completes the outstanding SRAM op in the cycle it is high (data valid that cycle).
  logic do_flush, do_write, do_rd_hit, do_rd_miss, do_fill, do_wr_done;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (MEM_W_EN)             state_nxt = WR_THRU;
          else if (MEM_R_EN && !hit) state_nxt = RD_MISS;
        end
      end
      RD_MISS: if (sram_ready) state_nxt = IDLE;
      WR_THRU: if (sram_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata      = '0;
    freeze     = 1'b0;
    do_flush   = 1'b0;
    do_write   = 1'b0;
    do_rd_hit  = 1'b0;
    do_rd_miss = 1'b0;
    do_fill    = 1'b0;
    do_wr_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          freeze   = 1'b1;
          do_flush = 1'b1;
        end else if (MEM_W_EN) begin
          freeze   = 1'b1;
          do_write = 1'b1;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata     = hit_word;
            do_rd_hit = 1'b1;
          end else begin
            freeze     = 1'b1;
            do_rd_miss = 1'b1;
          end
        end
      end
      RD_MISS: begin
        freeze = !sram_ready;
        if (sram_ready) begin
          rdata   = fill_word;
          do_fill = 1'b1;
        end
      end
      WR_THRU: begin
        freeze     = !sram_ready;
        do_wr_done = sram_ready;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_r_en  <= 1'b0;
      sram_w_en  <= 1'b0;
    end else begin
      if (do_write) begin
        sram_addr  <= addr;
        sram_wdata <= wdata;
        sram_w_en  <= 1'b1;
      end
      if (do_rd_miss) begin
        sram_addr <= addr;
        sram_r_en <= 1'b1;
      end
      if (do_fill)    sram_r_en <= 1'b0;
      if (do_wr_done) sram_w_en <= 1'b0;
    end
  end

  // LRU holds the way to replace next, so touching way0 points it at way1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (do_flush) begin
        valid0 <= '0;
        valid1 <= '0;
      end
      if (do_rd_hit || (do_write && hit && WRITE_UPDATE != 0)) lru[idx] <= hit0;
      if (do_write && WRITE_UPDATE == 0) begin
        if (hit0) valid0[idx] <= 1'b0;
        if (hit1) valid1[idx] <= 1'b0;
      end
      if (do_fill) begin
        if (lru[idx]) valid1[idx] <= 1'b1;
        else          valid0[idx] <= 1'b1;
        lru[idx] <= ~lru[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      if (lru[idx]) begin
        data1[idx] <= sram_rdata;
        tag1[idx]  <= tag;
      end else begin
        data0[idx] <= sram_rdata;
        tag0[idx]  <= tag;
      end
    end
    if (do_write && hit && WRITE_UPDATE != 0) begin
      if (hit0) begin
        if (word_sel) data0[idx][63:32] <= wdata;
        else          data0[idx][31:0]  <= wdata;
      end else begin
        if (word_sel) data1[idx][63:32] <= wdata;
        else          data1[idx][31:0]  <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (do_rd_hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (do_rd_miss && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench: instance 0 default policy, 1 invalidate-on-write-hit, 2 two-bit counters.
module tb_set_assoc_cache_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [3];
  logic [31:0] addr_v  [3];
  logic [31:0] wdata_v [3];
  logic        r_en_v  [3];
  logic        w_en_v  [3];
  logic        flush_v [3];
  logic        ready_v [3];
  logic [63:0] srd_v   [3];
  logic [31:0] rdata_v [3];
  logic        freeze_v[3];
  logic [31:0] saddr_v [3];
  logic [31:0] swdata_v[3];
  logic        sr_en_v [3];
  logic        sw_en_v [3];
  logic [1:0]  state_v [3];
  logic [15:0] hcnt0, mcnt0, hcnt1, mcnt1;
  logic [1:0]  hcnt2, mcnt2;

  int vec_cnt = 0;
  int err_cnt = 0;

  set_assoc_cache_ctrl u_dut (
    .clk(clk), .rst(rst_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .MEM_R_EN(r_en_v[0]), .MEM_W_EN(w_en_v[0]), .flush(flush_v[0]),
    .rdata(rdata_v[0]), .freeze(freeze_v[0]), .sram_addr(saddr_v[0]),
    .sram_wdata(swdata_v[0]), .sram_r_en(sr_en_v[0]), .sram_w_en(sw_en_v[0]),
    .sram_ready(ready_v[0]), .sram_rdata(srd_v[0]), .hit_cnt(hcnt0),
    .miss_cnt(mcnt0), .state_dbg(state_v[0]));

  set_assoc_cache_ctrl #(.WRITE_UPDATE(0)) u_inv (
    .clk(clk), .rst(rst_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .MEM_R_EN(r_en_v[1]), .MEM_W_EN(w_en_v[1]), .flush(flush_v[1]),
    .rdata(rdata_v[1]), .freeze(freeze_v[1]), .sram_addr(saddr_v[1]),
    .sram_wdata(swdata_v[1]), .sram_r_en(sr_en_v[1]), .sram_w_en(sw_en_v[1]),
    .sram_ready(ready_v[1]), .sram_rdata(srd_v[1]), .hit_cnt(hcnt1),
    .miss_cnt(mcnt1), .state_dbg(state_v[1]));

  set_assoc_cache_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst_v[2]), .addr(addr_v[2]), .wdata(wdata_v[2]),
    .MEM_R_EN(r_en_v[2]), .MEM_W_EN(w_en_v[2]), .flush(flush_v[2]),
    .rdata(rdata_v[2]), .freeze(freeze_v[2]), .sram_addr(saddr_v[2]),
    .sram_wdata(swdata_v[2]), .sram_r_en(sr_en_v[2]), .sram_w_en(sw_en_v[2]),
    .sram_ready(ready_v[2]), .sram_rdata(srd_v[2]), .hit_cnt(hcnt2),
    .miss_cnt(mcnt2), .state_dbg(state_v[2]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int k);
    addr_v[k]  = '0;
    wdata_v[k] = '0;
    r_en_v[k]  = 1'b0;
    w_en_v[k]  = 1'b0;
    flush_v[k] = 1'b0;
    ready_v[k] = 1'b0;
    srd_v[k]   = '0;
  endtask

  // Miss with one wait cycle before sram_ready; exp is the word the fill must forward.
  task automatic load_miss(input int k, input logic [31:0] a, input logic [63:0] line,
                           input logic [31:0] exp);
    addr_v[k] = a;
    r_en_v[k] = 1'b1;
    #1;
    check("miss_freeze", freeze_v[k], 1);
    cyc();
    check("miss_state", state_v[k], 1);
    check("miss_sram_r_en", sr_en_v[k], 1);
    check("miss_sram_w_en", sw_en_v[k], 0);
    check("miss_sram_addr", saddr_v[k], a);
    check("miss_wait_freeze", freeze_v[k], 1);
    cyc();
    ready_v[k] = 1'b1;
    srd_v[k]   = line;
    #1;
    check("fill_freeze", freeze_v[k], 0);
    check("fill_rdata", rdata_v[k], exp);
    cyc();
    check("fill_state", state_v[k], 0);
    check("fill_sram_r_en", sr_en_v[k], 0);
    clr(k);
  endtask

  task automatic load_hit(input int k, input logic [31:0] a, input logic [31:0] exp);
    addr_v[k] = a;
    r_en_v[k] = 1'b1;
    #1;
    check("hit_freeze", freeze_v[k], 0);
    check("hit_rdata", rdata_v[k], exp);
    cyc();
    check("hit_state", state_v[k], 0);
    clr(k);
  endtask

  task automatic store(input int k, input logic [31:0] a, input logic [31:0] d);
    addr_v[k]  = a;
    wdata_v[k] = d;
    w_en_v[k]  = 1'b1;
    #1;
    check("st_freeze", freeze_v[k], 1);
    cyc();
    check("st_state", state_v[k], 2);
    check("st_sram_w_en", sw_en_v[k], 1);
    check("st_sram_r_en", sr_en_v[k], 0);
    check("st_sram_addr", saddr_v[k], a);
    check("st_sram_wdata", swdata_v[k], d);
    check("st_wait_freeze", freeze_v[k], 1);
    cyc();
    check("st_hold_w_en", sw_en_v[k], 1);
    ready_v[k] = 1'b1;
    #1;
    check("st_done_freeze", freeze_v[k], 0);
    cyc();
    check("st_done_state", state_v[k], 0);
    check("st_done_w_en", sw_en_v[k], 0);
    clr(k);
  endtask

  localparam logic [63:0] L1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] LA = 64'hA1A1_A1A1_A0A0_A0A0;
  localparam logic [63:0] LB = 64'hB1B1_B1B1_B0B0_B0B0;
  localparam logic [63:0] LC = 64'hC1C1_C1C1_C0C0_C0C0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b0;
      clr(k);
    end
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;
    #1;
    check("rst_state", state_v[0], 0);
    check("rst_sram_r_en", sr_en_v[0], 0);
    check("rst_sram_w_en", sw_en_v[0], 0);
    check("rst_sram_addr", saddr_v[0], 0);
    check("rst_hit_cnt", hcnt0, 0);
    check("rst_miss_cnt", mcnt0, 0);
    check("idle_freeze", freeze_v[0], 0);
    check("idle_rdata", rdata_v[0], 0);

    // First miss and same-line hit on the other word.
    load_miss(0, 32'h100, L1, 32'h3333_4444);
    check("miss_cnt_1", mcnt0, 1);
    check("hit_cnt_0", hcnt0, 0);
    load_hit(0, 32'h104, 32'h1111_2222);
    check("hit_cnt_1", hcnt0, 1);

    // Index 0: A, B, A, C -> C evicts B; A still hits, B misses again.
    load_miss(0, 32'h000, LA, 32'hA0A0_A0A0);
    load_miss(0, 32'h200, LB, 32'hB0B0_B0B0);
    load_hit(0, 32'h000, 32'hA0A0_A0A0);
    load_miss(0, 32'h400, LC, 32'hC0C0_C0C0);
    load_hit(0, 32'h004, 32'hA1A1_A1A1);
    load_miss(0, 32'h204, LB, 32'hB1B1_B1B1);
    load_hit(0, 32'h000, 32'hA0A0_A0A0);
    check("lru_miss_cnt", mcnt0, 5);
    check("lru_hit_cnt", hcnt0, 4);

    // Write-hit update, then a write miss that must not allocate.
    store(0, 32'h100, 32'hDEAD_BEEF);
    load_hit(0, 32'h100, 32'hDEAD_BEEF);
    load_hit(0, 32'h104, 32'h1111_2222);
    store(0, 32'h800, 32'h1234_5678);
    load_miss(0, 32'h800, 64'h5555_6666_7777_8888, 32'h7777_8888);

    // Flush: one frozen cycle, then previously valid lines miss.
    flush_v[0] = 1'b1;
    #1;
    check("flush_freeze", freeze_v[0], 1);
    cyc();
    clr(0);
    #1;
    check("flush_state", state_v[0], 0);
    check("post_flush_freeze", freeze_v[0], 0);
    load_miss(0, 32'h100, L1, 32'h3333_4444);
    load_miss(0, 32'h000, LA, 32'hA0A0_A0A0);

    // Reset while a read miss is outstanding.
    addr_v[0] = 32'h900;
    r_en_v[0] = 1'b1;
    cyc();
    check("pre_rst_state", state_v[0], 1);
    rst_v[0] = 1'b0;
    cyc();
    check("mid_rst_state", state_v[0], 0);
    check("mid_rst_sram_r_en", sr_en_v[0], 0);
    check("mid_rst_hit_cnt", hcnt0, 0);
    check("mid_rst_miss_cnt", mcnt0, 0);
    rst_v[0] = 1'b1;
    clr(0);
    load_miss(0, 32'h100, L1, 32'h3333_4444);
    check("after_rst_miss_cnt", mcnt0, 1);

    // Invalidate-on-write-hit policy.
    load_miss(1, 32'h100, L1, 32'h3333_4444);
    load_hit(1, 32'h100, 32'h3333_4444);
    store(1, 32'h100, 32'hDEAD_BEEF);
    load_miss(1, 32'h100, 64'h1111_2222_DEAD_BEEF, 32'hDEAD_BEEF);
    check("inv_miss_cnt", mcnt1, 2);
    check("inv_hit_cnt", hcnt1, 1);

    // Two-bit counters saturate at 3.
    load_miss(2, 32'h100, L1, 32'h3333_4444);
    for (int i = 0; i < 5; i++) load_hit(2, 32'h100, 32'h3333_4444);
    check("sat_hit_cnt", hcnt2, 3);
    load_miss(2, 32'h200, LB, 32'hB0B0_B0B0);
    load_miss(2, 32'h300, LC, 32'hC0C0_C0C0);
    check("sat_miss_cnt_3", mcnt2, 3);
    load_miss(2, 32'h400, LA, 32'hA0A0_A0A0);
    load_miss(2, 32'h504, L1, 32'h1111_2222);
    check("sat_miss_cnt_hold", mcnt2, 3);
    check("sat_hit_cnt_hold", hcnt2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
